// File: rtl/gray_sweep_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gray_sweep_ctrl
//
// Walks a 4-bit code index from `first` to `last` (wrapping 15 -> 0). Each
// index is driven out on `bcd` to an external combinational Gray converter.
// The converter answer on `S_in` is sampled after HOLD_CYCLES settle cycles
// and presented downstream with a valid/ready handshake. Consecutive accepted
// codes of one sweep are checked for Gray adjacency, meaning they differ in
// exactly one bit. Violations raise a sticky `err` and bump a saturating
// counter.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   start      sweep request, honoured only while idle
//   first      first index of the sweep, captured with start
//   last       last index of the sweep, captured with start
//   bcd        registered index driven to the converter
//   S_in       converter output for the current bcd
//   out_valid  out_code/out_index hold a result
//   out_ready  downstream accepts the result
//   out_code   sampled converter result
//   out_index  index that produced out_code
//   busy       high whenever not idle
//   done       one-cycle pulse at sweep completion
//   err        sticky adjacency-violation flag
//   err_count  violation count, saturating at 31
// -----------------------------------------------------------------------------
module gray_sweep_ctrl #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] first,
  input  logic [3:0] last,
  output logic [3:0] bcd,
  input  logic [3:0] S_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_code,
  output logic [3:0] out_index,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Final value of the settle counter inside DRIVE.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] bcd_q, bcd_d;
  logic [3:0] last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] out_code_q, out_code_d;
  logic [3:0] out_index_q, out_index_d;
  logic       out_valid_q, out_valid_d;
  logic [3:0] prev_code_q, prev_code_d;
  logic       have_prev_q, have_prev_d;
  logic       err_q, err_d;
  logic [4:0] err_count_q, err_count_d;

  // True when a and b differ in exactly one bit position.
  function automatic logic gray_adjacent(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] diff;
    diff = a ^ b;
    return (diff != 4'd0) && ((diff & (diff - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    last_d      = last_q;
    hold_d      = hold_q;
    out_code_d  = out_code_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    prev_code_d = prev_code_q;
    have_prev_d = have_prev_q;
    err_d       = err_q;
    err_count_d = err_count_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d       = first;
          last_d      = last;
          hold_d      = 4'd0;
          have_prev_d = 1'b0;
          err_d       = 1'b0;
          err_count_d = 5'd0;
          state_d     = DRIVE;
        end
      end

      DRIVE: begin
        // bcd has been stable for HOLD_CYCLES cycles by the end of the last
        // one, so the converter output is settled and can be captured.
        if (hold_q == HOLD_LAST) begin
          hold_d      = 4'd0;
          out_code_d  = S_in;
          out_index_d = bcd_q;
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end

      PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          prev_code_d = out_code_q;
          have_prev_d = 1'b1;
          // The first transfer of a sweep has no predecessor to compare with.
          if (have_prev_q && !gray_adjacent(prev_code_q, out_code_q)) begin
            err_d       = 1'b1;
            err_count_d = sat_inc(err_count_q);
          end
          if (out_index_q == last_q) begin
            state_d = DONE;
          end else begin
            bcd_d   = bcd_q + 4'd1;
            state_d = DRIVE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bcd_q       <= 4'd0;
      last_q      <= 4'd0;
      hold_q      <= 4'd0;
      out_code_q  <= 4'd0;
      out_index_q <= 4'd0;
      out_valid_q <= 1'b0;
      prev_code_q <= 4'd0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      out_code_q  <= out_code_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      prev_code_q <= prev_code_d;
      have_prev_q <= have_prev_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bcd       = bcd_q;
  assign out_code  = out_code_q;
  assign out_index = out_index_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
`timescale 1ns/1ps
module tb_gray_sweep_ctrl;

  localparam int H = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] first, last;
  logic [3:0] bcd;
  logic [3:0] S_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_code, out_index;
  logic       busy, done, err;
  logic [4:0] err_count;

  // External converter model: binary-to-Gray, optionally broken at one index
  // (fault_idx = 16 disables the fault).
  logic [4:0] fault_idx = 5'd16;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int ready_mode = 0;
  int stall_cnt = 0;

  logic [7:0] exp_q[$];   // {index, code} per expected transfer
  logic [5:0] done_q[$];  // {err, err_count} per expected done pulse

  always #5 clk = ~clk;

  always_comb begin
    if (fault_idx == {1'b0, bcd}) S_in = 4'd0;
    else                          S_in = bcd ^ (bcd >> 1);
  end

  gray_sweep_ctrl #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .first(first), .last(last),
    .bcd(bcd), .S_in(S_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_index(out_index), .busy(busy), .done(done),
    .err(err), .err_count(err_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = stall 3 cycles on index 3.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && out_index == 4'd3 && stall_cnt < 3) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit hold_pend;
    logic [3:0] p_code, p_idx;
    logic [7:0] e;
    logic [5:0] d;
    hold_pend = 0;
    p_code = 0;
    p_idx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 0;
      end else begin
        if (hold_pend) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_code", int'(out_code), int'(p_code));
          chk("hold_index", int'(out_index), int'(p_idx));
        end
        hold_pend = out_valid && !out_ready;
        p_code = out_code;
        p_idx = out_index;
        if (out_valid && out_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL xfer_unexpected: got index %0d code %0d expected no transfer", out_index, out_code);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_index", int'(out_index), int'(e[7:4]));
            chk("xfer_code", int'(out_code), int'(e[3:0]));
          end
        end
        if (done) begin
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: got done=1 expected 0");
          end else begin
            d = done_q.pop_front();
            chk("done_err", int'(err), int'(d[5]));
            chk("done_err_count", int'(err_count), int'(d[4:0]));
          end
        end
      end
    end
  end

  // Reference model: enumerate the sweep and predict every transfer and the
  // final error state.
  task automatic build_model(input logic [3:0] f, input logic [3:0] l, input logic [4:0] flt,
                             output int n);
    logic [3:0] span, idx, code, prev;
    int errs;
    span = l - f;
    n = int'(span) + 1;
    errs = 0;
    idx = f;
    prev = 4'd0;
    for (int i = 0; i < n; i++) begin
      code = (flt == {1'b0, idx}) ? 4'd0 : (idx ^ (idx >> 1));
      if (i > 0 && $countones(prev ^ code) != 1) errs = (errs < 31) ? errs + 1 : 31;
      exp_q.push_back({idx, code});
      prev = code;
      idx = idx + 4'd1;
    end
    done_q.push_back({errs != 0, 5'(errs)});
  endtask

  task automatic run_sweep(input logic [3:0] f, input logic [3:0] l, input logic [4:0] flt,
                           input int rmode, input bit poke, input bit now);
    int n, cyc;
    bit seen, fin;
    build_model(f, l, flt, n);
    fault_idx = flt;
    ready_mode = rmode;
    stall_cnt = 0;
    if (!now) begin
      @(posedge clk); #1;
    end
    start = 1'b1; first = f; last = l;
    @(posedge clk); #1;
    start = 1'b0; first = 4'($urandom); last = 4'($urandom);
    cyc = 1; seen = 0; fin = 0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      chk("busy_active", int'(busy), 1);
      if (!seen && out_valid) begin
        seen = 1;
        chk("first_latency", cyc, 1 + H);
      end
      if (done) begin
        fin = 1;
        if (rmode == 0) chk("sweep_cycles", cyc, n * (H + 1) + 1);
      end else begin
        @(posedge clk); #1;
        cyc++;
        start = poke && (cyc == 5);
        if (start) begin first = 4'($urandom); last = 4'($urandom); end
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL sweep_timeout: got no done after %0d cycles expected done", cyc);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bcd"}, int'(bcd), 0);
    chk({tag, "_out_code"}, int'(out_code), 0);
    chk({tag, "_out_index"}, int'(out_index), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
  endtask

  initial begin
    int guard, base, n;
    logic [4:0] flt;
    rst = 1'b1; start = 1'b0; first = 4'd0; last = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // Full sweep, ideal converter, ready always high.
    run_sweep(4'd0, 4'd15, 5'd16, 0, 0, 0);
    // Broken converter at index 5: two adjacency violations.
    run_sweep(4'd0, 4'd15, 5'd5, 0, 0, 0);
    // Backpressure on index 3.
    run_sweep(4'd0, 4'd15, 5'd16, 2, 0, 0);
    // Wrap-around sweep.
    run_sweep(4'd14, 4'd1, 5'd16, 0, 0, 0);
    // Single element.
    run_sweep(4'd7, 4'd7, 5'd16, 0, 0, 0);
    // Start pulsed while busy must not disturb the sweep.
    run_sweep(4'd0, 4'd15, 5'd16, 0, 1, 0);

    // Reset after the third transfer of a sweep that already has errors.
    build_model(4'd0, 4'd15, 5'd1, n);
    fault_idx = 5'd1;
    ready_mode = 0;
    @(posedge clk); #1;
    base = xfer_cnt;
    start = 1'b1; first = 4'd0; last = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (xfer_cnt < base + 3 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (xfer_cnt < base + 3) begin
      checks++; errors++;
      $display("FAIL reset_wait_timeout: got %0d transfers expected 3", xfer_cnt - base);
    end
    #1;
    chk("pre_reset_err_count", int'(err_count), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    chk_zero("midreset");
    // Start in the very first cycle after reset.
    run_sweep(4'd3, 4'd6, 5'd16, 0, 0, 1);

    // Randomized sweeps with random backpressure and occasional faults.
    for (int k = 0; k < 25; k++) begin
      flt = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 15)) : 5'd16;
      run_sweep(4'($urandom), 4'($urandom), flt, 1, bit'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_sweep_ctrl.md
GRAY_SWEEP_CTRL -- requirements
Module: gray_sweep_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 1: settle cycles (1..15) between driving bcd and sampling S_in.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  request a sweep; sampled only in IDLE.
REQ-005 first  input  4  first code index of the sweep; latched on accepted start.
REQ-006 last  input  4  last code index of the sweep; latched on accepted start.
REQ-007 bcd  output  4  registered code index driven to the external combinational Gray converter.
REQ-008 S_in  input  4  converter output for the current bcd.
REQ-009 out_valid  output  1  out_code/out_index hold a result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_code  output  4  sampled converter result.
REQ-012 out_index  output  4  index that produced out_code.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the sweep completes.
REQ-015 err  output  1  sticky flag: a Gray adjacency violation occurred.
REQ-016 err_count  output  5  violation count, saturating at 31.

Function
REQ-017 The FSM SHALL have states IDLE, DRIVE, PRESENT, DONE.
REQ-018 IDLE: start=1 SHALL latch first/last, set bcd=first, clear err and err_count, and enter DRIVE on the next edge.
REQ-019 start SHALL be ignored in any state other than IDLE.
REQ-020 DRIVE SHALL last exactly HOLD_CYCLES cycles, then sample S_in into out_code and bcd into out_index, assert out_valid, and enter PRESENT.
REQ-021 PRESENT: out_code, out_index and out_valid SHALL stay stable while out_ready=0.
REQ-022 A transfer is the cycle with out_valid=1 and out_ready=1; on it out_valid SHALL deassert next cycle.
REQ-023 On each transfer except the first of a sweep, the block SHALL compute popcount(prev_code XOR out_code).
REQ-024 When that popcount is not 1, err SHALL set and err_count SHALL increment, saturating at 31.
REQ-025 If the transferred index equals last, the FSM SHALL enter DONE; otherwise bcd SHALL become (bcd+1) mod 16 and the FSM SHALL enter DRIVE.
REQ-026 The sweep length SHALL be ((last-first) mod 16)+1; first>last wraps 15->0, and first=last yields exactly one transfer.
REQ-027 DONE SHALL assert done for exactly one cycle, then return to IDLE; err and err_count SHALL hold until the next accepted start.
REQ-028 Minimum latency SHALL be 1+HOLD_CYCLES cycles from accepted start to the first out_valid.
REQ-029 With out_ready held high, each result after the first SHALL take HOLD_CYCLES+1 cycles.

Reset
REQ-030 rst=1 SHALL force IDLE and set bcd, out_code, out_index, out_valid, busy, done, err and err_count to 0, and clear the previous-code register.
REQ-031 rst SHALL take priority over all other inputs, including a sweep in progress; no done pulse SHALL follow.
REQ-032 After rst deasserts, the block SHALL accept start in the first cycle.

Verification
REQ-033 Full sweep, correct binary-to-Gray model, HOLD_CYCLES=1: first=0, last=15, out_ready=1 -> 16 transfers with out_code 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000; err=0; one done pulse.
REQ-034 Fault injection: model returns 0000 at index 5, full sweep -> transitions 0110->0000 and 0000->0101 both flagged; err=1 and err_count=2 at done.
REQ-035 Backpressure: out_ready=0 for 3 cycles at index 3 -> out_code=0010 and out_index=3 stay stable with out_valid=1; exactly one transfer of index 3 occurs.
REQ-036 Wrap: first=14, last=1 -> indices 14,15,0,1 with codes 1001,1000,0000,0001; err=0.
REQ-037 Single element: first=last=7 -> one transfer with code 0100, no adjacency check, done pulse.
REQ-038 Reset mid-sweep and busy-start: (a) rst after the third transfer -> all outputs 0 next cycle and no done pulse; (b) start pulsed while busy -> ignored, and the current sweep completes unchanged.
